// File: rtl/seven_segment_pkg.sv
// Shared types and the hex font for the seven-segment scan controller.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seven_segment_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    typedef logic [7:0] seg_t;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex + decimal-point decoder; active_low inverts every output bit.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       active_low,
    output seg_t       seg
);

    always_comb seg = {dp, HEX_SEG[nibble]} ^ {8{active_low}};

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment scan controller with a per-digit write buffer.
// Define SEVEN_SEGMENT_SCAN_BLANK_EN to insert an all-off gap between digit slots.
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [4:0]                wr_data,
    input  logic [DIGITS-1:0]         digit_en,
    output seg_t                      display_data,
    output logic [DIGITS-1:0]         select,
    output logic                      frame_tick
);

    localparam int AW      = $clog2(DIGITS);
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0]     SHOW_LOAD = CW'(PRESCALE - 1);
`ifdef SEVEN_SEGMENT_SCAN_BLANK_EN
    localparam logic [CW-1:0]     BLANK_LOAD = CW'(BLANK_CYCLES - 1);
`endif
    localparam logic              POLARITY  = (ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{POLARITY}};
    localparam seg_t              SEG_OFF   = {8{POLARITY}};

    scan_state_t   state, state_n;
    logic [AW-1:0] cur, cur_n, first_idx, next_idx;
    logic [CW-1:0] cnt, cnt_n;
    logic          tick_n, wrap;
    logic [4:0]    buffer [DIGITS];
    logic [4:0]    dec_in;
    seg_t          dec_seg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++) buffer[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < DIGITS)) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    // Loops run downward so the lowest index / shortest circular distance wins.
    always_comb begin
        first_idx = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (digit_en[i]) first_idx = AW'(i);
        end
        next_idx = cur;
        for (int k = DIGITS; k >= 1; k--) begin
            if (digit_en[(int'(cur) + k) % DIGITS]) next_idx = AW'((int'(cur) + k) % DIGITS);
        end
        wrap = (next_idx <= cur);
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        tick_n  = 1'b0;
        if (digit_en == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SHOW;
                    cur_n   = first_idx;
                    cnt_n   = SHOW_LOAD;
                end
                SHOW: begin
                    // Losing the current enable ends the slot just like expiry.
                    if (cnt == '0 || !digit_en[cur]) begin
`ifdef SEVEN_SEGMENT_SCAN_BLANK_EN
                        state_n = BLANK;
                        cnt_n   = BLANK_LOAD;
`else
                        cur_n   = next_idx;
                        cnt_n   = SHOW_LOAD;
                        tick_n  = wrap;
`endif
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
`ifdef SEVEN_SEGMENT_SCAN_BLANK_EN
                BLANK: begin
                    if (cnt == '0) begin
                        state_n = SHOW;
                        cur_n   = next_idx;
                        cnt_n   = SHOW_LOAD;
                        tick_n  = wrap;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Decode the digit that will be shown after this edge so select and data move together.
    assign dec_in = buffer[cur_n];

    seven_segment_decoder u_decoder (
        .nibble     (dec_in[3:0]),
        .dp         (dec_in[4]),
        .active_low (POLARITY),
        .seg        (dec_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cur          <= '0;
            cnt          <= '0;
            frame_tick   <= 1'b0;
            select       <= SEL_OFF;
            display_data <= SEG_OFF;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            cnt        <= cnt_n;
            frame_tick <= tick_n;
            if (state_n == SHOW) begin
                select       <= (DIGITS'(1) << cur_n) ^ SEL_OFF;
                display_data <= dec_seg;
            end else begin
                select       <= SEL_OFF;
                display_data <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: expected per-cycle outputs come from a slot schedule
// built from the enable mask, a letter-based segment font and a mirror of the buffer.
module tb_seven_segment_scan;

    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int ACTIVE_LOW   = 1;
`ifdef SEVEN_SEGMENT_SCAN_BLANK_EN
    localparam int GAP = BLANK_CYCLES;
`else
    localparam int GAP = 0;
`endif
    localparam logic [12:0] OFF = {1'b0, 4'hF, 8'hFF};

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] digit_en;
    logic [7:0] display_data;
    logic [3:0] select;
    logic       frame_tick;

    int          total = 0;
    int          bad   = 0;
    logic [4:0]  mbuf [DIGITS];
    logic [12:0] exp_q [$];
    string       font [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                               "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    seven_segment_scan #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .digit_en(digit_en), .display_data(display_data), .select(select), .frame_tick(frame_tick)
    );

    // ---------------- reference model ----------------
    function automatic logic [6:0] segs_of(input string lit);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b1;
        return s;
    endfunction

    function automatic logic [12:0] shown(input int d, input bit tick);
        logic [3:0] sel_hi;
        sel_hi = 4'(1 << d);
        return {tick, ~sel_hi, ~{mbuf[d][4], segs_of(font[mbuf[d][3:0]])}};
    endfunction

    function automatic int next_enabled(input logic [3:0] en, input int d);
        for (int k = 1; k <= DIGITS; k++) begin
            if (en[(d + k) % DIGITS]) return (d + k) % DIGITS;
        end
        return d;
    endfunction

    // Slots in visiting order: PRESCALE cycles lit, then GAP cycles dark.
    function automatic void build_sched(input logic [3:0] en, input int ncyc);
        int d, prev;
        bit first;
        exp_q.delete();
        d = next_enabled(en, DIGITS - 1);
        prev = 0;
        first = 1'b1;
        while (exp_q.size() < ncyc) begin
            for (int c = 0; c < PRESCALE; c++) exp_q.push_back(shown(d, (c == 0) && !first && (d <= prev)));
            for (int c = 0; c < GAP; c++) exp_q.push_back(OFF);
            prev = d;
            d = next_enabled(en, d);
            first = 1'b0;
        end
    endfunction

    // ---------------- checking ----------------
    function automatic logic [12:0] obs();
        return {frame_tick, select, display_data};
    endfunction

    task automatic check(input string tag, input logic [12:0] observed, input logic [12:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic write_digit(input logic [1:0] a, input logic [4:0] v);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = v;
        step();
        wr_en = 1'b0;
        mbuf[a] = v;
    endtask

    task automatic run_sched(input string tag);
        while (exp_q.size() > 0) begin
            step();
            check(tag, obs(), exp_q.pop_front());
        end
    endtask

    task automatic start_scan(input logic [3:0] en, input int ncyc, input string tag);
        digit_en = en;
        build_sched(en, ncyc);
        run_sched(tag);
    endtask

    task automatic stop_scan();
        digit_en = 4'b0000;
        step();
        check("idle_off", obs(), OFF);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [4:0] old_v, new_v;
        logic [3:0] en;

        rst = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        digit_en = 4'b1111;
        for (int i = 0; i < DIGITS; i++) mbuf[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_sel", {9'b0, select}, 13'h00F);
        check("reset_data", {5'b0, display_data}, 13'h0FF);
        check("reset_tick", {12'b0, frame_tick}, 13'h000);

        rst = 1'b1;
        build_sched(4'b1111, 24);
        run_sched("scan_all");
        stop_scan();

        write_digit(2'd0, 5'h10);
        write_digit(2'd1, 5'h08);
        digit_en = 4'b0001;
        build_sched(4'b0001, 12);
        step();
        check("dec0_lit", {5'b0, display_data}, 13'h040);
        check("dec0", obs(), exp_q.pop_front());
        run_sched("dec0");
        stop_scan();

        digit_en = 4'b0010;
        build_sched(4'b0010, 12);
        step();
        check("dec1_lit", {5'b0, display_data}, 13'h080);
        check("dec1", obs(), exp_q.pop_front());
        run_sched("dec1");
        stop_scan();

        for (int i = 0; i < DIGITS; i++) write_digit(2'(i), 5'($urandom_range(0, 31)));
        start_scan(4'b1010, 30, "skip");
        stop_scan();

        repeat (6) begin
            repeat ($urandom_range(1, 4)) write_digit(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            en = 4'($urandom_range(1, 15));
            start_scan(en, $urandom_range(16, 40), "rand_scan");
            stop_scan();
        end

        old_v = mbuf[2];
        new_v = old_v ^ 5'h1F;
        digit_en = 4'b0100;
        step();
        check("mid_s1", obs(), shown(2, 1'b0));
        step();
        check("mid_s2", obs(), shown(2, 1'b0));
        wr_en = 1'b1;
        wr_addr = 2'd2;
        wr_data = new_v;
        step();
        wr_en = 1'b0;
        check("mid_s3", obs(), shown(2, 1'b0));
        mbuf[2] = new_v;
        step();
        check("mid_s4", obs(), shown(2, 1'b0));
        step();
        check("mid_end", obs(), (GAP > 0) ? OFF : shown(2, 1'b1));
        stop_scan();

        digit_en = 4'b0011;
        step();
        check("loss_s1", obs(), shown(0, 1'b0));
        digit_en = 4'b0010;
        step();
        check("loss_end", obs(), (GAP > 0) ? OFF : shown(1, 1'b0));
        stop_scan();

        digit_en = 4'b1111;
        step();
        step();
        check("pre_rst", obs(), shown(0, 1'b0));
        #2 rst = 1'b0;
        #1 check("async_rst", obs(), OFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
